// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM capture block.
//
// Contents:
//   CNT_W_DEF        default width of the period / high-time counters
//   TIMEOUT_CYC_DEF  default number of cycles without a rising edge before
//                    the measurement is declared stale
//   FILT_LEN_DEF     default number of stable samples the optional glitch
//                    filter waits for
//   state_e          measurement FSM states
package pwm_pkg;

  localparam int unsigned CNT_W_DEF       = 25;
  localparam logic [24:0] TIMEOUT_CYC_DEF = 25'd33554431;
  localparam int unsigned FILT_LEN_DEF    = 4;

  // IDLE: no edge seen yet, MEASURE: counting an interval,
  // STALE: input stopped toggling, outputs frozen and TIMEOUT raised
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    STALE   = 2'd2
  } state_e;

endpackage

// File: rtl/pwm_glitch_filter.sv
// Glitch filter for an already synchronized single-bit level.
// The output follows the input only after FILT_LEN consecutive samples
// differ from the current output, so pulses shorter than FILT_LEN cycles
// never reach dout. Both edges are delayed by the same FILT_LEN cycles,
// which keeps measured periods and high times intact.
//
// Parameters:
//   FILT_LEN  number of consecutive equal samples required (>= 1)
// Ports:
//   CLK    in   clock, rising edge
//   RST_N  in   asynchronous active-low reset
//   din    in   synchronized input level
//   dout   out  filtered level
module pwm_glitch_filter
  import pwm_pkg::*;
#(
  parameter int unsigned FILT_LEN = FILT_LEN_DEF
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(FILT_LEN - 1);

  logic [CW-1:0] runCnt_q;
  logic          dout_q;

  // runCnt_q counts how many samples in a row have disagreed with the
  // current output; any agreeing sample restarts the count
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      runCnt_q <= '0;
      dout_q   <= 1'b0;
    end else if (din == dout_q) begin
      runCnt_q <= '0;
    end else if (runCnt_q == LastCnt) begin
      dout_q   <= din;
      runCnt_q <= '0;
    end else begin
      runCnt_q <= runCnt_q + CW'(1);
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture.
// PWM_IN is synchronized (2 flops), optionally glitch filtered, and its
// rising edges delimit measurement intervals. Each completed interval
// updates PERIOD and HIGH_TIME and pulses VALID for one cycle. If no rising
// edge arrives within TIMEOUT_CYC cycles, TIMEOUT is raised and held until
// the next edge; the interval that straddles a timeout is never reported.
//
// Optional feature: define GLITCH_FILTER_EN to insert pwm_glitch_filter
// between the synchronizer and the edge detector (adds FILT_LEN cycles of
// latency and rejects pulses shorter than FILT_LEN cycles).
//
// Parameters:
//   CNT_W        counter / output width
//   TIMEOUT_CYC  cycles without a rising edge before TIMEOUT
//   FILT_LEN     glitch filter length (only with GLITCH_FILTER_EN)
// Ports:
//   CLK        in   clock, rising edge
//   RST_N      in   asynchronous active-low reset
//   PWM_IN     in   PWM waveform, asynchronous to CLK
//   PERIOD     out  last measured period in cycles (rise to rise)
//   HIGH_TIME  out  last measured high time in cycles
//   VALID      out  one-cycle pulse when PERIOD/HIGH_TIME update
//   TIMEOUT    out  high while the input has stopped toggling
//   LEVEL      out  conditioned input level
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned      CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] TIMEOUT_CYC = TIMEOUT_CYC_DEF,
  parameter int unsigned      FILT_LEN    = FILT_LEN_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PWM_IN,
  output logic [CNT_W-1:0] PERIOD,
  output logic [CNT_W-1:0] HIGH_TIME,
  output logic             VALID,
  output logic             TIMEOUT,
  output logic             LEVEL
);

  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  // A zero-length filter would have no meaning; reject it at elaboration
  if (FILT_LEN < 1) begin : g_filt_len_check
    $error("pwm_capture: FILT_LEN must be at least 1");
  end

  logic             syncMeta_q;
  logic             syncOut_q;
  logic             level;
  logic             levelDly_q;
  logic             rise;

  state_e           state_q;
  logic [CNT_W-1:0] cntP_q;
  logic [CNT_W-1:0] cntH_q;
  logic [CNT_W-1:0] period_q;
  logic [CNT_W-1:0] high_q;
  logic             valid_q;
  logic             timeout_q;

  // Two-flop synchronizer plus the one-cycle delayed level used for
  // rising-edge detection
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
      levelDly_q <= 1'b0;
    end else begin
      syncMeta_q <= PWM_IN;
      syncOut_q  <= syncMeta_q;
      levelDly_q <= level;
    end
  end

`ifdef GLITCH_FILTER_EN
  pwm_glitch_filter #(
    .FILT_LEN(FILT_LEN)
  ) u_filter (
    .CLK  (CLK),
    .RST_N(RST_N),
    .din  (syncOut_q),
    .dout (level)
  );
`else
  assign level = syncOut_q;
`endif

  assign rise = level & ~levelDly_q;

  // Measurement FSM. Counters stop at TIMEOUT_CYC because reaching it
  // forces STALE, where they are held, so they can never wrap. The very
  // first edge and the edge that ends a stale period only start a fresh
  // interval; only an edge seen in MEASURE closes a reportable one.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= IDLE;
      cntP_q    <= '0;
      cntH_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rise) begin
            state_q <= MEASURE;
            cntP_q  <= CntOne;
            cntH_q  <= CntOne;
          end else if (cntP_q == TIMEOUT_CYC) begin
            state_q   <= STALE;
            timeout_q <= 1'b1;
          end else begin
            cntP_q <= cntP_q + CntOne;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_q <= cntP_q;
            high_q   <= cntH_q;
            valid_q  <= 1'b1;
            cntP_q   <= CntOne;
            cntH_q   <= CntOne;
          end else if (cntP_q == TIMEOUT_CYC) begin
            state_q   <= STALE;
            timeout_q <= 1'b1;
          end else begin
            cntP_q <= cntP_q + CntOne;
            if (level && (cntH_q != TIMEOUT_CYC)) begin
              cntH_q <= cntH_q + CntOne;
            end
          end
        end
        STALE: begin
          if (rise) begin
            state_q   <= MEASURE;
            timeout_q <= 1'b0;
            cntP_q    <= CntOne;
            cntH_q    <= CntOne;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign PERIOD    = period_q;
  assign HIGH_TIME = high_q;
  assign VALID     = valid_q;
  assign TIMEOUT   = timeout_q;
  assign LEVEL     = levelDly_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture.
// dutA uses a long timeout for the measurement scenarios, dutB uses
// TIMEOUT_CYC=100 for the timeout scenarios; both see the same PWM input
// and reset. Inputs are driven and outputs sampled on the falling edge.
// Expectations follow GLITCH_FILTER_EN when it is defined.
module tb_pwm_capture;

`ifdef GLITCH_FILTER_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk;
  logic        rst_n;
  logic        pwm;
  logic [24:0] periodA, highA, periodB, highB;
  logic        validA, timeoutA, levelA;
  logic        validB, timeoutB, levelB;

  int total;
  int bad;
  int cyc;

  logic [24:0] qPA[$];
  logic [24:0] qHA[$];
  int          qTA[$];
  logic [24:0] qPB[$];
  logic [24:0] qHB[$];

  pwm_capture #(
    .CNT_W(25), .TIMEOUT_CYC(25'd10000), .FILT_LEN(4)
  ) dutA (
    .CLK(clk), .RST_N(rst_n), .PWM_IN(pwm), .PERIOD(periodA),
    .HIGH_TIME(highA), .VALID(validA), .TIMEOUT(timeoutA), .LEVEL(levelA)
  );

  pwm_capture #(
    .CNT_W(25), .TIMEOUT_CYC(25'd100), .FILT_LEN(4)
  ) dutB (
    .CLK(clk), .RST_N(rst_n), .PWM_IN(pwm), .PERIOD(periodB),
    .HIGH_TIME(highB), .VALID(validB), .TIMEOUT(timeoutB), .LEVEL(levelB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive lvl for n cycles, recording every VALID seen on either DUT
  task automatic seg(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (validA) begin
        qPA.push_back(periodA);
        qHA.push_back(highA);
        qTA.push_back(cyc);
      end
      if (validB) begin
        qPB.push_back(periodB);
        qHB.push_back(highB);
      end
      pwm = lvl;
    end
  endtask

  task automatic clearQ();
    qPA.delete(); qHA.delete(); qTA.delete(); qPB.delete(); qHB.delete();
  endtask

  task automatic doReset();
    @(negedge clk);
    rst_n = 1'b0;
    pwm   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clearQ();
  endtask

  task automatic test_reset();
    int firstK;
    rst_n = 1'b0;
    pwm   = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (periodA !== 25'd0) begin bad++; $display("[TB] FAIL rst_periodA: got %0d expected 0", periodA); end
    total++; if (highA !== 25'd0) begin bad++; $display("[TB] FAIL rst_highA: got %0d expected 0", highA); end
    total++; if (validA !== 1'b0) begin bad++; $display("[TB] FAIL rst_validA: got %b expected 0", validA); end
    total++; if (timeoutA !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeoutA: got %b expected 0", timeoutA); end
    total++; if (levelA !== 1'b0) begin bad++; $display("[TB] FAIL rst_levelA: got %b expected 0", levelA); end
    total++; if (periodB !== 25'd0) begin bad++; $display("[TB] FAIL rst_periodB: got %0d expected 0", periodB); end
    total++; if (timeoutB !== 1'b0) begin bad++; $display("[TB] FAIL rst_timeoutB: got %b expected 0", timeoutB); end
    rst_n  = 1'b1;
    firstK = -1;
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (timeoutB && firstK < 0) firstK = k;
    end
    total++; if (firstK !== 101) begin bad++; $display("[TB] FAIL idle_timeout_cycle: got %0d expected 101", firstK); end
    total++; if (timeoutA !== 1'b0) begin bad++; $display("[TB] FAIL idle_timeoutA: got %b expected 0", timeoutA); end
  endtask

  task automatic test_steady();
    int base;
    doReset();
    base = cyc + 1;
    for (int p = 0; p < 5; p++) begin
      seg(1'b1, 500);
      seg(1'b0, 1000);
    end
    total++; if (qPA.size() !== 4) begin bad++; $display("[TB] FAIL steady_count: got %0d expected 4", qPA.size()); end
    for (int i = 0; i < qPA.size(); i++) begin
      total++; if (qPA[i] !== 25'd1500) begin bad++; $display("[TB] FAIL steady_period[%0d]: got %0d expected 1500", i, qPA[i]); end
      total++; if (qHA[i] !== 25'd500) begin bad++; $display("[TB] FAIL steady_high[%0d]: got %0d expected 500", i, qHA[i]); end
    end
    if (qTA.size() > 0) begin
      total++; if (qTA[0] !== base + 1500 + LAT) begin bad++; $display("[TB] FAIL steady_latency: got %0d expected %0d", qTA[0] - base - 1500, LAT); end
    end
    total++; if (timeoutA !== 1'b0) begin bad++; $display("[TB] FAIL steady_timeout: got %b expected 0", timeoutA); end
  endtask

  task automatic test_period_switch();
    int eP[7] = '{1500, 1500, 1500, 2250, 3000, 3000, 3000};
    int eH[7] = '{750, 750, 750, 750, 1500, 1500, 1500};
    doReset();
    for (int p = 0; p < 3; p++) begin
      seg(1'b1, 750);
      seg(1'b0, 750);
    end
    seg(1'b1, 750);
    seg(1'b0, 1500);
    for (int p = 0; p < 3; p++) begin
      seg(1'b1, 1500);
      seg(1'b0, 1500);
    end
    seg(1'b1, 20);
    total++; if (qPA.size() !== 7) begin bad++; $display("[TB] FAIL switch_count: got %0d expected 7", qPA.size()); end
    for (int i = 0; i < qPA.size() && i < 7; i++) begin
      total++; if (qPA[i] !== 25'(eP[i])) begin bad++; $display("[TB] FAIL switch_period[%0d]: got %0d expected %0d", i, qPA[i], eP[i]); end
      total++; if (qHA[i] !== 25'(eH[i])) begin bad++; $display("[TB] FAIL switch_high[%0d]: got %0d expected %0d", i, qHA[i], eH[i]); end
    end
  endtask

  task automatic test_timeout();
    int base;
    int firstTo;
    int nValid;
    doReset();
    base = cyc + 1;
    for (int p = 0; p < 3; p++) begin
      seg(1'b1, 10);
      seg(1'b0, 10);
    end
    total++; if (qPB.size() !== 2) begin bad++; $display("[TB] FAIL to_pre_count: got %0d expected 2", qPB.size()); end
    firstTo = -1;
    nValid  = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      cyc++;
      if (timeoutB && firstTo < 0) firstTo = cyc;
      if (validB) nValid++;
      pwm = 1'b0;
    end
    total++; if (firstTo !== base + 40 + LAT + 100) begin bad++; $display("[TB] FAIL to_cycle: got %0d expected %0d", firstTo - base, 40 + LAT + 100); end
    total++; if (nValid !== 0) begin bad++; $display("[TB] FAIL to_no_valid: got %0d expected 0", nValid); end
    total++; if (periodB !== 25'd20) begin bad++; $display("[TB] FAIL to_period_hold: got %0d expected 20", periodB); end
    total++; if (highB !== 25'd10) begin bad++; $display("[TB] FAIL to_high_hold: got %0d expected 10", highB); end
    clearQ();
    seg(1'b1, 10);
    seg(1'b0, 10);
    seg(1'b1, 10);
    seg(1'b0, 20);
    total++; if (timeoutB !== 1'b0) begin bad++; $display("[TB] FAIL to_cleared: got %b expected 0", timeoutB); end
    total++; if (qPB.size() !== 1) begin bad++; $display("[TB] FAIL to_recover_count: got %0d expected 1", qPB.size()); end
    if (qPB.size() > 0) begin
      total++; if (qPB[0] !== 25'd20) begin bad++; $display("[TB] FAIL to_recover_period: got %0d expected 20", qPB[0]); end
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    seg(1'b1, 500);
    seg(1'b0, 1000);
    seg(1'b1, 500);
    seg(1'b0, 1000);
    seg(1'b1, 200);
    total++; if (qPA.size() !== 2) begin bad++; $display("[TB] FAIL mid_pre_count: got %0d expected 2", qPA.size()); end
    #3;
    rst_n = 1'b0;
    pwm   = 1'b0;
    #1;
    total++; if (periodA !== 25'd0) begin bad++; $display("[TB] FAIL mid_periodA: got %0d expected 0", periodA); end
    total++; if (highA !== 25'd0) begin bad++; $display("[TB] FAIL mid_highA: got %0d expected 0", highA); end
    total++; if (validA !== 1'b0) begin bad++; $display("[TB] FAIL mid_validA: got %b expected 0", validA); end
    total++; if (timeoutA !== 1'b0) begin bad++; $display("[TB] FAIL mid_timeoutA: got %b expected 0", timeoutA); end
    total++; if (levelA !== 1'b0) begin bad++; $display("[TB] FAIL mid_levelA: got %b expected 0", levelA); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clearQ();
    seg(1'b0, 300);
    seg(1'b1, 500);
    seg(1'b0, 1000);
    seg(1'b1, 20);
    total++; if (qPA.size() !== 1) begin bad++; $display("[TB] FAIL mid_post_count: got %0d expected 1", qPA.size()); end
    if (qPA.size() > 0) begin
      total++; if (qPA[0] !== 25'd1500) begin bad++; $display("[TB] FAIL mid_post_period: got %0d expected 1500", qPA[0]); end
    end
  endtask

  task automatic test_glitch();
    int eP[$];
    int eH[$];
`ifdef GLITCH_FILTER_EN
    eP = '{1500, 1500};
    eH = '{500, 500};
`else
    eP = '{1000, 500, 1000, 500};
    eH = '{500, 2, 500, 2};
`endif
    doReset();
    for (int p = 0; p < 2; p++) begin
      seg(1'b1, 500);
      seg(1'b0, 500);
      seg(1'b1, 2);
      seg(1'b0, 498);
    end
    seg(1'b1, 20);
    total++; if (qPA.size() !== eP.size()) begin bad++; $display("[TB] FAIL glitch_count: got %0d expected %0d", qPA.size(), eP.size()); end
    for (int i = 0; i < qPA.size() && i < eP.size(); i++) begin
      total++; if (qPA[i] !== 25'(eP[i])) begin bad++; $display("[TB] FAIL glitch_period[%0d]: got %0d expected %0d", i, qPA[i], eP[i]); end
      total++; if (qHA[i] !== 25'(eH[i])) begin bad++; $display("[TB] FAIL glitch_high[%0d]: got %0d expected %0d", i, qHA[i], eH[i]); end
    end
  endtask

  task automatic test_min_period();
    int expCount;
`ifdef GLITCH_FILTER_EN
    expCount = 0;
`else
    expCount = 5;
`endif
    doReset();
    for (int p = 0; p < 6; p++) begin
      seg(1'b1, 1);
      seg(1'b0, 1);
    end
    seg(1'b0, 10);
    total++; if (qPA.size() !== expCount) begin bad++; $display("[TB] FAIL min_count: got %0d expected %0d", qPA.size(), expCount); end
    for (int i = 0; i < qPA.size(); i++) begin
      total++; if (qPA[i] !== 25'd2) begin bad++; $display("[TB] FAIL min_period[%0d]: got %0d expected 2", i, qPA[i]); end
      total++; if (qHA[i] !== 25'd1) begin bad++; $display("[TB] FAIL min_high[%0d]: got %0d expected 1", i, qHA[i]); end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst_n = 1'b0;
    pwm   = 1'b0;
    test_reset();
    test_steady();
    test_period_switch();
    test_timeout();
    test_reset_mid();
    test_glitch();
    test_min_period();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
